// File: rtl/data_chk.sv
`default_nettype none
// data_chk: receive checker for comma-framed PRBS frames (head, payload, tail) with saturating stats.
// Optional macro DATA_CHK_BIT_ERR_EN builds the bit-error accumulator; otherwise bit_err_cnt is 0. Rev 1.0
module data_chk #(
    parameter int         PRBS_LENGTH = 8,
    parameter bit         INV_PATTERN = 1'b1,
    parameter int         POLY_LENGHT = 9,
    parameter int         POLY_TAP    = 5,
    parameter logic [9:0] COMMA       = 10'h333
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  data_in,
    input  logic        cnt_clr,
    output logic        locked,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_frame_cnt,
    output logic [15:0] err_word_cnt,
    output logic [31:0] bit_err_cnt
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        TAIL    = 2'd2
    } state_t;

    localparam logic [5:0] LAST = 6'(PRBS_LENGTH - 1);

    state_t               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic                 flag_q, flag_d;
    logic                 done_q, done_d;
    logic                 ok_q, ok_d;
    logic                 mismatch;
    logic [1:POLY_LENGHT] lfsr_q, lfsr_d;
    logic [9:0]           exp_q, exp_d;
    logic                 prbs_en;
    logic [15:0]          frame_cnt_q, err_frame_cnt_q, err_word_cnt_q;

    // Local generator: ten serial LFSR steps per word, identical to the transmitter's PRBS_ANY.
    always_comb begin
        lfsr_d = lfsr_q;
        exp_d  = '0;
        for (int i = 0; i < 10; i++) begin
            exp_d[i] = lfsr_d[POLY_TAP] ^ lfsr_d[POLY_LENGHT] ^ INV_PATTERN;
            lfsr_d   = {lfsr_d[POLY_TAP] ^ lfsr_d[POLY_LENGHT], lfsr_d[1:POLY_LENGHT-1]};
        end
    end

    assign prbs_en = (state_q == PAYLOAD) && (cnt_q < LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '1;
            exp_q  <= '1;
        end else if (state_q == HUNT) begin
            lfsr_q <= '1;
            exp_q  <= '1;
        end else if (prbs_en) begin
            lfsr_q <= lfsr_d;
            exp_q  <= exp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flag_d   = flag_q;
        done_d   = 1'b0;
        ok_d     = 1'b0;
        mismatch = 1'b0;
        case (state_q)
            HUNT: begin
                if (data_in == COMMA) begin
                    state_d = PAYLOAD;
                    cnt_d   = '0;
                    flag_d  = 1'b0;
                end
            end
            PAYLOAD: begin
                mismatch = (data_in != exp_q);
                if (mismatch) flag_d = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = TAIL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            TAIL: begin
                mismatch = (data_in != COMMA);
                if (mismatch) flag_d = 1'b1;
                done_d  = 1'b1;
                ok_d    = !(flag_q || mismatch);
                state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
        end
    end

    // Statistics: clear wins over a same-cycle increment; saturate at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q     <= '0;
            err_frame_cnt_q <= '0;
            err_word_cnt_q  <= '0;
        end else if (cnt_clr) begin
            frame_cnt_q     <= '0;
            err_frame_cnt_q <= '0;
            err_word_cnt_q  <= '0;
        end else begin
            if (done_d && (frame_cnt_q != 16'hFFFF))
                frame_cnt_q <= frame_cnt_q + 16'd1;
            if (done_d && !ok_d && (err_frame_cnt_q != 16'hFFFF))
                err_frame_cnt_q <= err_frame_cnt_q + 16'd1;
            if (mismatch && (err_word_cnt_q != 16'hFFFF))
                err_word_cnt_q <= err_word_cnt_q + 16'd1;
        end
    end

`ifdef DATA_CHK_BIT_ERR_EN
    logic [31:0] bit_err_q;
    logic [9:0]  diff;
    logic [3:0]  pop;
    logic [32:0] bit_sum;

    always_comb begin
        diff = data_in ^ ((state_q == TAIL) ? COMMA : exp_q);
        pop  = '0;
        for (int i = 0; i < 10; i++) pop = pop + {3'd0, diff[i]};
        bit_sum = {1'b0, bit_err_q} + {29'd0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bit_err_q <= '0;
        else if (cnt_clr)
            bit_err_q <= '0;
        else if (state_q != HUNT)
            bit_err_q <= bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
    end

    assign bit_err_cnt = bit_err_q;
`else
    assign bit_err_cnt = 32'd0;
`endif

    assign locked        = (state_q != HUNT);
    assign frame_done    = done_q;
    assign frame_ok      = ok_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_frame_cnt = err_frame_cnt_q;
    assign err_word_cnt  = err_word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_data_chk.sv
`default_nettype none
// tb_data_chk: directed frames against data_chk with a serial-LFSR reference for the payload.
`timescale 1ns/1ps
module tb_data_chk;

    localparam int         PLEN  = 8;
    localparam logic [9:0] COMMA = 10'h333;

    logic        clk;
    logic        rst_n;
    logic [9:0]  data_in;
    logic        cnt_clr;
    logic        locked;
    logic        frame_done;
    logic        frame_ok;
    logic [15:0] frame_cnt;
    logic [15:0] err_frame_cnt;
    logic [15:0] err_word_cnt;
    logic [31:0] bit_err_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit ok_log[$];
    int done_cyc[$];

    data_chk #(
        .PRBS_LENGTH (PLEN),
        .INV_PATTERN (1'b1),
        .POLY_LENGHT (9),
        .POLY_TAP    (5),
        .COMMA       (COMMA)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .cnt_clr       (cnt_clr),
        .locked        (locked),
        .frame_done    (frame_done),
        .frame_ok      (frame_ok),
        .frame_cnt     (frame_cnt),
        .err_frame_cnt (err_frame_cnt),
        .err_word_cnt  (err_word_cnt),
        .bit_err_cnt   (bit_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && frame_done) begin
            ok_log.push_back(frame_ok);
            done_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter reference: word k is the all-ones seed advanced k times by 10 serial steps.
    function automatic logic [9:0] exp_word(input int k);
        logic [1:9] st;
        logic       a;
        logic [9:0] w;
        st = '1;
        w  = 10'h3FF;
        for (int s = 0; s < k; s++) begin
            for (int b = 0; b < 10; b++) begin
                a    = st[5] ^ st[9];
                w[b] = ~a;
                st   = {a, st[1:8]};
            end
        end
        return w;
    endfunction

    task automatic send_word(input logic [9:0] w, input logic clr);
        @(negedge clk);
        data_in = w;
        cnt_clr = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_word(10'h000, 1'b0);
    endtask

    task automatic send_frame(input int bad_word, input logic [9:0] mask,
                              input logic [9:0] tail, input logic clr_on_tail);
        logic [9:0] w;
        send_word(COMMA, 1'b0);
        for (int k = 0; k < PLEN; k++) begin
            w = exp_word(k);
            if (k == bad_word) w = w ^ mask;
            send_word(w, 1'b0);
        end
        send_word(tail, clr_on_tail);
    endtask

    task automatic clear_stats();
        send_word(10'h000, 1'b1);
        idle(1);
        ok_log.delete();
        done_cyc.delete();
    endtask

    int  exp_bits;
    bit  gap_locked;
    int  n_before;

    initial begin
        rst_n   = 1'b0;
        data_in = 10'h000;
        cnt_clr = 1'b0;
        #23;
        check("rst_locked",     {31'd0, locked},        32'd0);
        check("rst_frame_done", {31'd0, frame_done},    32'd0);
        check("rst_frame_ok",   {31'd0, frame_ok},      32'd0);
        check("rst_frame_cnt",  {16'd0, frame_cnt},     32'd0);
        check("rst_err_frame",  {16'd0, err_frame_cnt}, 32'd0);
        check("rst_err_word",   {16'd0, err_word_cnt},  32'd0);
        check("rst_bit_err",    bit_err_cnt,            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Five back-to-back clean frames.
        for (int f = 0; f < 5; f++) send_frame(-1, 10'h000, COMMA, 1'b0);
        idle(3);
        check("clean_done_n", ok_log.size(), 32'd5);
        for (int f = 0; f < 5 && f < ok_log.size(); f++)
            check($sformatf("clean_ok%0d", f), {31'd0, ok_log[f]}, 32'd1);
        for (int f = 1; f < 5 && f < done_cyc.size(); f++)
            check($sformatf("clean_space%0d", f), done_cyc[f] - done_cyc[f-1], 32'd10);
        check("clean_frame_cnt", {16'd0, frame_cnt},     32'd5);
        check("clean_err_frame", {16'd0, err_frame_cnt}, 32'd0);
        check("clean_err_word",  {16'd0, err_word_cnt},  32'd0);
        check("clean_bit_err",   bit_err_cnt,            32'd0);
        clear_stats();
        check("clr_frame_cnt",   {16'd0, frame_cnt},     32'd0);

        // Bit 3 of payload word 2 flipped in the middle frame.
        send_frame(-1, 10'h000, COMMA, 1'b0);
        send_frame(2, 10'h008, COMMA, 1'b0);
        send_frame(-1, 10'h000, COMMA, 1'b0);
        idle(3);
`ifdef DATA_CHK_BIT_ERR_EN
        exp_bits = 1;
`else
        exp_bits = 0;
`endif
        check("flip_done_n", ok_log.size(), 32'd3);
        if (ok_log.size() == 3) begin
            check("flip_ok0", {31'd0, ok_log[0]}, 32'd1);
            check("flip_ok1", {31'd0, ok_log[1]}, 32'd0);
            check("flip_ok2", {31'd0, ok_log[2]}, 32'd1);
        end
        check("flip_frame_cnt", {16'd0, frame_cnt},     32'd3);
        check("flip_err_frame", {16'd0, err_frame_cnt}, 32'd1);
        check("flip_err_word",  {16'd0, err_word_cnt},  32'd1);
        check("flip_bit_err",   bit_err_cnt,            exp_bits);
        clear_stats();

        // Corrupted tail, then a clean frame.
        send_frame(-1, 10'h000, 10'h000, 1'b0);
        idle(2);
        check("tail_locked",   {31'd0, locked},       32'd0);
        check("tail_err_word", {16'd0, err_word_cnt}, 32'd1);
`ifdef DATA_CHK_BIT_ERR_EN
        check("tail_bit_err",  bit_err_cnt,           32'd6);
`else
        check("tail_bit_err",  bit_err_cnt,           32'd0);
`endif
        send_frame(-1, 10'h000, COMMA, 1'b0);
        idle(3);
        check("tail_done_n", ok_log.size(), 32'd2);
        if (ok_log.size() == 2) begin
            check("tail_ok0", {31'd0, ok_log[0]}, 32'd0);
            check("tail_ok1", {31'd0, ok_log[1]}, 32'd1);
        end
        check("tail_frame_cnt", {16'd0, frame_cnt},     32'd2);
        check("tail_err_frame", {16'd0, err_frame_cnt}, 32'd1);
        clear_stats();

        // Idle gaps of 0..7 words between frames.
        gap_locked = 1'b0;
        for (int g = 0; g < 8; g++) begin
            send_frame(-1, 10'h000, COMMA, 1'b0);
            for (int j = 0; j < g; j++) begin
                send_word(10'h000, 1'b0);
                if (locked) gap_locked = 1'b1;
            end
        end
        idle(3);
        check("gap_locked",    {31'd0, gap_locked},   32'd0);
        check("gap_done_n",    ok_log.size(),         32'd8);
        check("gap_frame_cnt", {16'd0, frame_cnt},    32'd8);
        check("gap_err_word",  {16'd0, err_word_cnt}, 32'd0);
        clear_stats();

        // Saturation of frame_cnt.
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        send_frame(-1, 10'h000, COMMA, 1'b0);
        idle(3);
        check("sat_frame_cnt", {16'd0, frame_cnt},     32'h0000_FFFF);
        check("sat_err_frame", {16'd0, err_frame_cnt}, 32'd0);

        // cnt_clr on the tail edge of an errored frame beats the increments.
        ok_log.delete();
        send_frame(0, 10'h001, COMMA, 1'b1);
        idle(3);
        check("clrinc_done_n",    ok_log.size(),          32'd1);
        if (ok_log.size() == 1) check("clrinc_ok", {31'd0, ok_log[0]}, 32'd0);
        check("clrinc_frame_cnt", {16'd0, frame_cnt},     32'd0);
        check("clrinc_err_frame", {16'd0, err_frame_cnt}, 32'd0);
        check("clrinc_err_word",  {16'd0, err_word_cnt},  32'd0);
        check("clrinc_bit_err",   bit_err_cnt,            32'd0);
        clear_stats();

        // Asynchronous reset at payload word 4.
        send_frame(-1, 10'h000, COMMA, 1'b0);
        idle(2);
        check("prer_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        send_word(COMMA, 1'b0);
        for (int k = 0; k < 4; k++) send_word(exp_word(k), 1'b0);
        check("prer_locked", {31'd0, locked}, 32'd1);
        @(negedge clk);
        data_in = exp_word(4);
        rst_n   = 1'b0;
        #1;
        check("arst_locked",    {31'd0, locked},     32'd0);
        check("arst_frame_cnt", {16'd0, frame_cnt},  32'd0);
        check("arst_done",      {31'd0, frame_done}, 32'd0);
        n_before = ok_log.size();
        @(negedge clk);
        rst_n   = 1'b1;
        data_in = 10'h000;
        idle(12);
        check("arst_no_done", ok_log.size(), n_before);
        send_frame(-1, 10'h000, COMMA, 1'b0);
        idle(3);
        check("arst_next_done_n", ok_log.size(), n_before + 1);
        if (ok_log.size() == n_before + 1)
            check("arst_next_ok", {31'd0, ok_log[n_before]}, 32'd1);
        check("arst_next_frame_cnt", {16'd0, frame_cnt},    32'd1);
        check("arst_next_err_word",  {16'd0, err_word_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/data_chk.md
Name: data_chk

Overview:
- Receive-side checker for the framed PRBS test pattern.
- Frame format on the 10-bit word stream, one word per clk:
  - Head comma 10'b1100_1100_11 (10'h333).
  - PRBS_LENGTH PRBS words.
  - Tail comma 10'h333.
  - All-zero words when the transmitter is idle.
- The block locks onto heads, regenerates the expected PRBS locally, compares payload and tail word-by-word, and reports per-frame pass/fail and saturating statistics.
- It sits at the loopback/receive end of the colour-filter test link, opposite the frame generator.

Parameters:
- PRBS_LENGTH, 8, payload words per frame; legal range 1..32.
- INV_PATTERN, 1, passed to the local PRBS_ANY; must match the transmitter.
- POLY_LENGHT, 9, PRBS polynomial length; must match the transmitter.
- POLY_TAP, 5, PRBS polynomial tap; must match the transmitter.
- COMMA, 10'h333, head/tail word.

Ports:
- clk  in  1  single clock; word sampled every rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  10  received word stream.
- cnt_clr  in  1  synchronous clear of all statistics counters, active high.
- locked  out  1  high while the FSM is in PAYLOAD or TAIL.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_ok  out  1  valid with frame_done: 1 = all payload words and the tail matched.
- frame_cnt  out  16  completed frames, saturating.
- err_frame_cnt  out  16  frames with frame_ok=0, saturating.
- err_word_cnt  out  16  mismatched payload/tail words, saturating.
- bit_err_cnt  out  32  mismatched bits (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=HUNT, word counter=0, local PRBS held in reset, all outputs 0.
- Expected payload word k (k=0..PRBS_LENGTH-1): the output of a local PRBS_ANY (CHK_MODE=0, NBITS=10, same parameters) after k EN pulses following release from reset.
  - Local PRBS RST=1 in HUNT; RST=0 otherwise.
  - EN=1 in PAYLOAD when word counter < PRBS_LENGTH-1.
  - This reproduces the transmitter sequence exactly.
- FSM:
  - HUNT: data_in==COMMA -> PAYLOAD, counter=0. Any other word stays in HUNT; zeros are idle, not errors.
  - PAYLOAD: compare data_in against expected. Mismatch sets the sticky frame-error flag and increments err_word_cnt. Payload errors never drop lock.
    - counter==PRBS_LENGTH-1 -> TAIL, counter=0.
    - Otherwise counter+1.
  - TAIL: compare data_in against COMMA; mismatch sets the flag and increments err_word_cnt. Always -> HUNT.
  - A back-to-back head on the following cycle is caught by HUNT with no lost word: transmitter tail -> head -> payload spacing is 1 cycle apart.
- frame_done/frame_ok are registered: they pulse in the cycle after the edge that samples the tail word.
  - frame_cnt increments on that edge.
  - err_frame_cnt increments on that edge if the flag is set.
  - The flag clears on entry to PAYLOAD.
- A payload word equal to COMMA is treated as payload; commas are only recognised in HUNT and TAIL.
- Counters saturate at all-ones; there is no wrap.
- cnt_clr has priority over a simultaneous increment: the counter becomes 0 and the increment is lost. cnt_clr does not affect FSM or lock.
- Reset mid-frame: immediate return to HUNT. A partial frame is never reported.
- Latency: one word per clk throughput; status latency is 1 cycle after the tail.

Optional Feature:
- Macro DATA_CHK_BIT_ERR_EN.
- Defined:
  - bit_err_cnt accumulates popcount(data_in ^ expected) for every PAYLOAD and TAIL word.
  - 32-bit, saturating add.
  - Cleared by cnt_clr and reset.
- Not defined: bit_err_cnt tied to 32'd0; no XOR/popcount logic is built.

Test Plan:
- Clean stream: generator with send_enable held high for 5 frames, PRBS_LENGTH=8 -> 5 frame_done pulses spaced 10 cycles apart, all frame_ok=1, frame_cnt=5, err counters=0.
- Single-bit flip: invert bit 3 of payload word 2 in frame 1 of 3.
  - Frame 1 frame_ok=0; frames 0 and 2 ok.
  - err_frame_cnt=1, err_word_cnt=1.
  - bit_err_cnt=1 with DATA_CHK_BIT_ERR_EN, else 0.
- Corrupt tail: tail forced to 10'h000 -> frame_ok=0, err_word_cnt=1, FSM back in HUNT; next clean frame passes.
- Idle gaps: frames separated by 0–7 zero words -> no errors, frame_cnt matches the number sent, locked=0 during gaps.
- Saturation/clear:
  - Preload frame_cnt to 16'hFFFF (force), send 1 frame -> stays 16'hFFFF.
  - Assert cnt_clr in the same cycle as a frame_done increment -> counters read 0.
- Async reset mid-payload: rst_n low for 1 cycle at payload word 4 -> all outputs 0 immediately; no frame_done for the broken frame; next full frame passes.
